// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of the single 1M x 16 SRAM controller.
//
// One access at a time. The granted request's rw/addr/wdata are latched into the mem_* field
// registers. mem_valid is pulsed for exactly one cycle. The fields are then held until
// mem_ready or the watchdog expires. Completion is returned as a one-cycle reqN_ready pulse on
// the granted port. timeout_err accompanies that pulse when the access was aborted.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   reqN_valid/rw/addr/wdata  request from requester N (N = 0 instruction side, 1 data side)
//   reqN_ready, reqN_rdata    completion pulse and held read data for requester N
//   mem_valid/rw/addr/wdata   request pulse and held fields to the SRAM controller
//   mem_ready, mem_rdata      completion and read data from the SRAM controller
//   timeout_err               pulse alongside reqN_ready when the watchdog aborted the access

module sram_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64  // legal range 2..1023
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    input  logic        req0_rw,
    input  logic [19:0] req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic [15:0] req0_rdata,

    input  logic        req1_valid,
    input  logic        req1_rw,
    input  logic [19:0] req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic [15:0] req1_rdata,

    output logic        mem_valid,
    output logic        mem_rw,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,

    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [9:0] WdogLast = 10'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        abort_q, abort_d;
    logic [9:0]  wdog_q, wdog_d;
    logic        mem_rw_q, mem_rw_d;
    logic [19:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] req0_rdata_q, req0_rdata_d;
    logic [15:0] req1_rdata_q, req1_rdata_d;

    // Port chosen if a grant happens this cycle: a lone requester wins outright, a tie goes to
    // the port that did not win last time.
    logic pick;
    assign pick = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        abort_d      = abort_q;
        wdog_d       = wdog_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        req0_rdata_d = req0_rdata_q;
        req1_rdata_d = req1_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    mem_rw_d     = pick ? req1_rw    : req0_rw;
                    mem_addr_d   = pick ? req1_addr  : req0_addr;
                    mem_wdata_d  = pick ? req1_wdata : req0_wdata;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                wdog_d  = '0;
                abort_d = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                if (mem_ready) begin
                    if (grant_q) begin
                        req1_rdata_d = mem_rdata;
                    end else begin
                        req0_rdata_d = mem_rdata;
                    end
                    state_d = StResp;
                end else if (wdog_q == WdogLast) begin
                    // Abandon the access; the controller is never re-pulsed for it.
                    if (grant_q) begin
                        req1_rdata_d = 16'h0000;
                    end else begin
                        req0_rdata_d = 16'h0000;
                    end
                    abort_d = 1'b1;
                    state_d = StResp;
                end else begin
                    wdog_d = wdog_q + 10'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;  // so port 0 wins the first tie
            grant_q      <= 1'b0;
            abort_q      <= 1'b0;
            wdog_q       <= '0;
            mem_rw_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            req0_rdata_q <= '0;
            req1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            abort_q      <= abort_d;
            wdog_q       <= wdog_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            req0_rdata_q <= req0_rdata_d;
            req1_rdata_q <= req1_rdata_d;
        end
    end

    // Pulses decode directly from the state register, so reset clears them immediately.
    assign mem_valid   = (state_q == StIssue);
    assign req0_ready  = (state_q == StResp) && !grant_q;
    assign req1_ready  = (state_q == StResp) && grant_q;
    assign timeout_err = (state_q == StResp) && abort_q;

    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign req0_rdata  = req0_rdata_q;
    assign req1_rdata  = req1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter (TIMEOUT_CYCLES = 8) with a latency-programmable SRAM
// controller model. A vector table covers single transactions; hand sequences cover reset,
// fairness, back-to-back requests, a stray mem_ready and reset in the middle of an access.

module tb_sram_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_rw, req0_ready;
    logic [19:0] req0_addr;
    logic [15:0] req0_wdata, req0_rdata;
    logic        req1_valid, req1_rw, req1_ready;
    logic [19:0] req1_addr;
    logic [15:0] req1_wdata, req1_rdata;
    logic        mem_valid, mem_rw, mem_ready;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        timeout_err;

    always #5 clk = ~clk;

    sram_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_rw     (req0_rw),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_rw     (req1_rw),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rdata  (req1_rdata),
        .mem_valid   (mem_valid),
        .mem_rw      (mem_rw),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .timeout_err (timeout_err)
    );

    // SRAM controller model: mem_ready pulses model_lat cycles after the mem_valid cycle;
    // model_lat = 0 means it never answers.
    int          model_lat;
    logic [15:0] model_data;
    logic        model_ready;
    logic        stray_ready;
    logic        m_busy;
    int          m_cnt;

    assign mem_ready = model_ready | stray_ready;
    assign mem_rdata = mem_ready ? model_data : 16'hDEAD;

    always @(posedge clk) begin
        model_ready <= 1'b0;
        if (!rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (mem_valid && model_lat != 0) begin
            if (model_lat == 1) begin
                model_ready <= 1'b1;
            end else begin
                m_busy <= 1'b1;
                m_cnt  <= model_lat - 1;
            end
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                model_ready <= 1'b1;
                m_busy      <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_rd0, exp_rd1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;      // bit 0 = port 0
        logic        rw0;
        logic [19:0] addr0;
        logic [15:0] wdata0;
        logic        rw1;
        logic [19:0] addr1;
        logic [15:0] wdata1;
        int          lat;        // model latency, 0 = dead
        logic [15:0] data;       // model read data
        logic        exp_grant;
        logic [15:0] exp_rdata;
        logic        exp_to;
        int          exp_cyc;    // cycle of reqN_ready, request presented at cycle 0
    } vec_t;

    vec_t vecs[8];

    // Called just after a posedge with the DUT idle; returns just after a posedge, idle again.
    task automatic run_vec(input string tag, input vec_t v);
        logic [19:0] ea;
        logic        ew;
        logic [15:0] ewd;
        logic        seen, grant, to, stable, wrong_rdy, stray_to;
        logic [15:0] rd0, rd1;
        int          vcyc, rcyc, pulses;
        ea = v.exp_grant ? v.addr1  : v.addr0;
        ew = v.exp_grant ? v.rw1    : v.rw0;
        ewd = v.exp_grant ? v.wdata1 : v.wdata0;
        model_lat  = v.lat;
        model_data = v.data;
        req0_valid = v.valid[0];
        req0_rw    = v.rw0;
        req0_addr  = v.addr0;
        req0_wdata = v.wdata0;
        req1_valid = v.valid[1];
        req1_rw    = v.rw1;
        req1_addr  = v.addr1;
        req1_wdata = v.wdata1;
        seen = 1'b0; grant = 1'b0; to = 1'b0; stable = 1'b1; wrong_rdy = 1'b0; stray_to = 1'b0;
        rd0 = '0; rd1 = '0; vcyc = -1; rcyc = -1; pulses = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (mem_valid) begin
                pulses++;
                if (vcyc < 0) vcyc = n;
            end
            if (n >= 1 && (mem_addr !== ea || mem_rw !== ew || mem_wdata !== ewd)) stable = 1'b0;
            if ((v.exp_grant ? req0_ready : req1_ready) === 1'b1) wrong_rdy = 1'b1;
            if (timeout_err && !(req0_ready || req1_ready)) stray_to = 1'b1;
            if (req0_ready || req1_ready) begin
                seen  = 1'b1;
                rcyc  = n;
                grant = req1_ready;
                to    = timeout_err;
                rd0   = req0_rdata;
                rd1   = req1_rdata;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (v.exp_grant) exp_rd1 = v.exp_rdata;
        else exp_rd0 = v.exp_rdata;
        chk({tag, "_ready_seen"},   32'(seen),      32'd1);
        chk({tag, "_grant"},        32'(grant),     32'(v.exp_grant));
        chk({tag, "_rdata0"},       32'(rd0),       32'(exp_rd0));
        chk({tag, "_rdata1"},       32'(rd1),       32'(exp_rd1));
        chk({tag, "_timeout_err"},  32'(to),        32'(v.exp_to));
        chk({tag, "_valid_cycle"},  32'(vcyc),      32'd1);
        chk({tag, "_valid_pulses"}, 32'(pulses),    32'd1);
        chk({tag, "_ready_cycle"},  32'(rcyc),      32'(v.exp_cyc));
        chk({tag, "_fields_held"},  32'(stable),    32'd1);
        chk({tag, "_other_ready"},  32'(wrong_rdy), 32'd0);
        chk({tag, "_stray_to"},     32'(stray_to),  32'd0);
    endtask

    // Holds valid on the ports in mask for nacc completions (model latency 1).
    task automatic run_stream(input string tag, input logic [1:0] mask, input int nacc,
                              input logic first_grant);
        int   readies, pulses, last_rdy, extra;
        logic expg, order_ok, spacing_ok;
        readies = 0; pulses = 0; last_rdy = -100; extra = 0;
        expg = first_grant; order_ok = 1'b1; spacing_ok = 1'b1;
        model_lat  = 1;
        model_data = 16'h3C3C;
        req0_rw = 1'b0; req0_addr = 20'h11111; req0_wdata = 16'h0101;
        req1_rw = 1'b0; req1_addr = 20'h22222; req1_wdata = 16'h0202;
        req0_valid = mask[0];
        req1_valid = mask[1];
        for (int n = 0; n < 200 && readies < nacc; n++) begin
            @(negedge clk);
            if (mem_valid) begin
                pulses++;
                if (readies > 0 && n != last_rdy + 2) spacing_ok = 1'b0;
            end
            if (req0_ready || req1_ready) begin
                if (req1_ready !== expg) order_ok = 1'b0;
                if (expg) exp_rd1 = 16'h3C3C;
                else exp_rd0 = 16'h3C3C;
                readies++;
                last_rdy = n;
                if (mask == 2'b11) expg = ~expg;
            end
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (mem_valid || req0_ready || req1_ready) extra++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_completions"}, 32'(readies),    32'(nacc));
        chk({tag, "_mem_pulses"},  32'(pulses),     32'(nacc));
        chk({tag, "_grant_order"}, 32'(order_ok),   32'd1);
        chk({tag, "_spacing"},     32'(spacing_ok), 32'd1);
        chk({tag, "_no_extra"},    32'(extra),      32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulses"}, 32'({mem_valid, req0_ready, req1_ready, timeout_err}), 32'd0);
        chk({tag, "_mem_rw_addr"}, 32'({mem_rw, mem_addr}), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_rdata"}, {req0_rdata, req1_rdata}, 32'd0);
    endtask

    initial begin
        vec_t tv;
        int   rdy_cnt;

        //                valid  rw0   addr0      wdata0    rw1   addr1      wdata1
        //                lat  data      grant rdata     to    cyc
        vecs[0] = '{2'b01, 1'b0, 20'h00ABC, 16'h0000, 1'b0, 20'h00000, 16'h0000,
                    2, 16'h1234, 1'b0, 16'h1234, 1'b0, 4};
        vecs[1] = '{2'b10, 1'b0, 20'h00000, 16'h0000, 1'b1, 20'hFFFFF, 16'hBEEF,
                    3, 16'h5555, 1'b1, 16'h5555, 1'b0, 5};
        vecs[2] = '{2'b11, 1'b0, 20'h12345, 16'h1111, 1'b0, 20'h54321, 16'h2222,
                    1, 16'hA5A5, 1'b0, 16'hA5A5, 1'b0, 3};
        vecs[3] = '{2'b11, 1'b1, 20'h0AAAA, 16'h3333, 1'b0, 20'h05555, 16'h4444,
                    4, 16'h0F0F, 1'b1, 16'h0F0F, 1'b0, 6};
        vecs[4] = '{2'b01, 1'b0, 20'h00100, 16'h0000, 1'b0, 20'h00000, 16'h0000,
                    0, 16'h9999, 1'b0, 16'h0000, 1'b1, 10};
        vecs[5] = '{2'b01, 1'b0, 20'h00001, 16'h0000, 1'b0, 20'h00000, 16'h0000,
                    2, 16'hCAFE, 1'b0, 16'hCAFE, 1'b0, 4};
        vecs[6] = '{2'b10, 1'b0, 20'h00000, 16'h0000, 1'b1, 20'h80000, 16'hFFFF,
                    5, 16'h7777, 1'b1, 16'h7777, 1'b0, 7};
        vecs[7] = '{2'b11, 1'b1, 20'h0F0F0, 16'h1357, 1'b1, 20'h70707, 16'hAAAA,
                    1, 16'h2468, 1'b0, 16'h2468, 1'b0, 3};

        req0_rw = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_rw = 1'b0; req1_addr = '0; req1_wdata = '0;
        model_lat = 0; model_data = '0; stray_ready = 1'b0;
        do_reset(2);

        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;

        // mem_ready while idle must be ignored.
        stray_ready = 1'b1;
        @(posedge clk);
        #1;
        stray_ready = 1'b0;
        rdy_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (mem_valid || req0_ready || req1_ready || timeout_err) rdy_cnt++;
        end
        chk("stray_ready_idle", 32'(rdy_cnt), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Tie from reset: strict alternation starting at port 0.
        do_reset(1);
        run_stream("alt", 2'b11, 6, 1'b0);
        // Port 0 alone, re-requesting on the edge ending RESP.
        run_stream("b2b", 2'b01, 3, 1'b0);

        // Reset one cycle during WAIT of a port-0 access the controller never answers.
        model_lat  = 0;
        req0_rw    = 1'b1;
        req0_addr  = 20'h3ABCD;
        req0_wdata = 16'h5A5A;
        req0_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        do_reset(1);
        @(negedge clk);
        chk_all_zero("midwait_reset");
        rdy_cnt = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (req0_ready || req1_ready || timeout_err || mem_valid) rdy_cnt++;
        end
        chk("midwait_no_ready", 32'(rdy_cnt), 32'd0);
        @(posedge clk);
        #1;
        tv = '{2'b11, 1'b0, 20'h00042, 16'h0000, 1'b0, 20'h00043, 16'h0000,
               2, 16'h6161, 1'b0, 16'h6161, 1'b0, 4};
        run_vec("post_reset_tie", tv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
